// File: rtl/ray_scheduler_pkg.sv
// Shared types and constants for the ray scheduler: fixed-point vectors,
// scheduler state encodings and default display geometry.
package ray_scheduler_pkg;

  typedef logic signed [15:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  localparam logic [1:0] RS_IDLE     = 2'd0;
  localparam logic [1:0] RS_DISPATCH = 2'd1;
  localparam logic [1:0] RS_DRAIN    = 2'd2;

  localparam int DEFAULT_DISPLAY_WIDTH  = 320;
  localparam int DEFAULT_DISPLAY_HEIGHT = 180;
  localparam int DEFAULT_H_BITS         = 9;
  localparam int DEFAULT_V_BITS         = 8;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ray_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, searching from a pointer that
// moves to one past the winner after every grant.
module rr_arbiter
  import ray_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_bits(N)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan farthest-first so the candidate closest to the pointer wins last.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = wrap_add(ptr, k);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= wrap_add(grant_idx, 1);
    end
  end

endmodule

// File: rtl/ray_scheduler.sv
// Frame controller: dispatches pixels in raster order to free ray units and
// serialises their finished colours onto one frame-buffer write port.
module ray_scheduler
  import ray_scheduler_pkg::*;
#(
  parameter int NUM_UNITS      = 4,
  parameter int DISPLAY_WIDTH  = DEFAULT_DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = DEFAULT_DISPLAY_HEIGHT,
  parameter int H_BITS         = DEFAULT_H_BITS,
  parameter int V_BITS         = DEFAULT_V_BITS,
  parameter int ADDR_BITS      = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  vec3                           ray_origin_in,
  input  vec3                           cam_forward_in,
  input  logic [2:0]                    fractal_sel_in,
  output vec3                           unit_ray_origin_out,
  output vec3                           unit_ray_direction_out,
  output logic [2:0]                    unit_fractal_sel_out,
  output logic [H_BITS-1:0]             unit_hcount_out,
  output logic [V_BITS-1:0]             unit_vcount_out,
  output logic [NUM_UNITS-1:0]          unit_valid_out,
  input  logic [NUM_UNITS-1:0]          unit_ready_in,
  input  logic [NUM_UNITS*H_BITS-1:0]   unit_hcount_in,
  input  logic [NUM_UNITS*V_BITS-1:0]   unit_vcount_in,
  input  logic [NUM_UNITS*4-1:0]        unit_color_in,
  output logic                          fb_we_out,
  output logic [ADDR_BITS-1:0]          fb_addr_out,
  output logic [3:0]                    fb_data_out,
  output logic                          busy_out,
  output logic                          frame_done_out
);

  localparam int IW = idx_bits(NUM_UNITS);
  localparam logic [H_BITS-1:0] X_LAST = H_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [V_BITS-1:0] Y_LAST = V_BITS'(DISPLAY_HEIGHT - 1);

  logic [1:0]           state;
  logic [H_BITS-1:0]    x;
  logic [V_BITS-1:0]    y;
  logic [NUM_UNITS-1:0] inflight, armed, pending, complete, eligible, dispatch_sel, grant;
  logic [IW-1:0]        grant_idx;
  logic                 grant_valid;
  logic                 dispatch_fire;

  logic [H_BITS-1:0] res_h  [NUM_UNITS];
  logic [V_BITS-1:0] res_v  [NUM_UNITS];
  logic [3:0]        res_c  [NUM_UNITS];
  logic [H_BITS-1:0] pend_h [NUM_UNITS];
  logic [V_BITS-1:0] pend_v [NUM_UNITS];
  logic [3:0]        pend_c [NUM_UNITS];

  // A unit keeps ready high for a cycle after accepting work, so completion
  // is only trusted once ready has been seen low (armed) and then high again.
  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign res_h[gi]    = unit_hcount_in[gi*H_BITS +: H_BITS];
      assign res_v[gi]    = unit_vcount_in[gi*V_BITS +: V_BITS];
      assign res_c[gi]    = unit_color_in[gi*4 +: 4];
      assign complete[gi] = inflight[gi] & armed[gi] & unit_ready_in[gi];
    end
  endgenerate

  assign eligible      = unit_ready_in & ~inflight & ~pending;
  assign dispatch_sel  = eligible & (~eligible + NUM_UNITS'(1));
  assign dispatch_fire = (state == RS_DISPATCH) && (eligible != '0);

  rr_arbiter #(.N(NUM_UNITS), .IW(IW)) u_wr_arb (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .req         (pending),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state                  <= RS_IDLE;
      x                      <= '0;
      y                      <= '0;
      inflight               <= '0;
      armed                  <= '0;
      pending                <= '0;
      unit_ray_origin_out    <= '0;
      unit_ray_direction_out <= '0;
      unit_fractal_sel_out   <= '0;
      unit_hcount_out        <= '0;
      unit_vcount_out        <= '0;
      unit_valid_out         <= '0;
      fb_we_out              <= 1'b0;
      fb_addr_out            <= '0;
      fb_data_out            <= '0;
      busy_out               <= 1'b0;
      frame_done_out         <= 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        pend_h[i] <= '0;
        pend_v[i] <= '0;
        pend_c[i] <= '0;
      end
    end else begin
      unit_valid_out <= '0;
      fb_we_out      <= 1'b0;
      frame_done_out <= 1'b0;

      case (state)
        RS_IDLE: begin
          if (start_in) begin
            unit_ray_origin_out    <= ray_origin_in;
            unit_ray_direction_out <= cam_forward_in;
            unit_fractal_sel_out   <= fractal_sel_in;
            x                      <= '0;
            y                      <= '0;
            busy_out               <= 1'b1;
            state                  <= RS_DISPATCH;
          end
        end
        RS_DISPATCH: begin
          if (dispatch_fire) begin
            unit_valid_out  <= dispatch_sel;
            unit_hcount_out <= x;
            unit_vcount_out <= y;
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) state <= RS_DRAIN;
              else             y     <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        RS_DRAIN: begin
          if (inflight == '0 && pending == '0) begin
            frame_done_out <= 1'b1;
            busy_out       <= 1'b0;
            state          <= RS_IDLE;
          end
        end
        default: state <= RS_IDLE;
      endcase

      inflight <= (inflight | (dispatch_fire ? dispatch_sel : '0)) & ~complete;
      armed    <= (armed | (inflight & ~unit_ready_in)) & ~complete;
      pending  <= (pending & ~grant) | complete;

      for (int i = 0; i < NUM_UNITS; i++) begin
        if (complete[i]) begin
          pend_h[i] <= res_h[i];
          pend_v[i] <= res_v[i];
          pend_c[i] <= res_c[i];
        end
      end

      if (grant_valid) begin
        fb_we_out   <= 1'b1;
        fb_addr_out <= ADDR_BITS'(pend_v[grant_idx]) * ADDR_BITS'(DISPLAY_WIDTH)
                     + ADDR_BITS'(pend_h[grant_idx]);
        fb_data_out <= pend_c[grant_idx];
      end
    end
  end

endmodule

// File: tb/tb_ray_scheduler.sv
// Directed bench for ray_scheduler: two behavioural ray units on a 4x2 screen,
// scoreboarded frame writes plus cycle-exact checks around dispatch and writeback.
module tb_ray_scheduler;
  import ray_scheduler_pkg::*;

  localparam int NU = 2;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 3;
  localparam int VB = 2;
  localparam int AB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start;
  vec3              origin, fwd;
  logic [2:0]       sel;
  vec3              origin_out, dir_out;
  logic [2:0]       sel_out;
  logic [HB-1:0]    hcount;
  logic [VB-1:0]    vcount;
  logic [NU-1:0]    valid;
  logic [NU-1:0]    ready;
  logic [NU*HB-1:0] res_h;
  logic [NU*VB-1:0] res_v;
  logic [NU*4-1:0]  res_c;
  logic             fb_we;
  logic [AB-1:0]    fb_addr;
  logic [3:0]       fb_data;
  logic             busy;
  logic             done;

  ray_scheduler #(
    .NUM_UNITS(NU), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
    .H_BITS(HB), .V_BITS(VB), .ADDR_BITS(AB)
  ) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .ray_origin_in(origin), .cam_forward_in(fwd), .fractal_sel_in(sel),
    .unit_ray_origin_out(origin_out), .unit_ray_direction_out(dir_out),
    .unit_fractal_sel_out(sel_out), .unit_hcount_out(hcount), .unit_vcount_out(vcount),
    .unit_valid_out(valid), .unit_ready_in(ready), .unit_hcount_in(res_h),
    .unit_vcount_in(res_v), .unit_color_in(res_c), .fb_we_out(fb_we),
    .fb_addr_out(fb_addr), .fb_data_out(fb_data), .busy_out(busy),
    .frame_done_out(done)
  );

  // Behavioural ray units: ready stays high one cycle after accepting work,
  // then low until cnt reaches dur, then high again with colour h+v.
  int            cnt  [NU];
  int            dur  [NU];
  logic          nr   [NU];
  logic [HB-1:0] h_st [NU];
  logic [VB-1:0] v_st [NU];

  generate
    for (genvar gi = 0; gi < NU; gi++) begin : g_model
      assign ready[gi]            = !nr[gi] && (cnt[gi] == 0 || cnt[gi] == 1);
      assign res_h[gi*HB +: HB]   = h_st[gi];
      assign res_v[gi*VB +: VB]   = v_st[gi];
      assign res_c[gi*4 +: 4]     = 4'(h_st[gi]) + 4'(v_st[gi]);
    end
  endgenerate

  always @(posedge clk) begin
    for (int i = 0; i < NU; i++) begin
      if (!rst) begin
        cnt[i] <= 0;
      end else if (cnt[i] != 0) begin
        cnt[i] <= (cnt[i] >= dur[i]) ? 0 : cnt[i] + 1;
      end else if (valid[i] && ready[i]) begin
        cnt[i]  <= 1;
        h_st[i] <= hcount;
        v_st[i] <= vcount;
      end
    end
  end

  // Scoreboard sampled on the falling edge; cleared when a frame is accepted.
  int   cyc, wr_count, done_count, done_err, data_err, valid_err, last_we_cyc;
  int   addr_seen [W*H];
  int   disp_count [NU];
  logic outst [NU];
  int   opix [NU];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      for (int i = 0; i < NU; i++) outst[i] = 1'b0;
    end else begin
      if (start && !busy) begin
        wr_count = 0; done_count = 0; done_err = 0; data_err = 0; valid_err = 0;
        for (int a = 0; a < W*H; a++) addr_seen[a] = 0;
        for (int i = 0; i < NU; i++) begin disp_count[i] = 0; outst[i] = 1'b0; end
      end
      if (fb_we) begin
        wr_count++;
        addr_seen[fb_addr]++;
        if (fb_data !== 4'((int'(fb_addr) % W) + (int'(fb_addr) / W))) data_err++;
        for (int i = 0; i < NU; i++)
          if (outst[i] && opix[i] == int'(fb_addr)) outst[i] = 1'b0;
        last_we_cyc = cyc;
      end
      if (done) begin
        done_count++;
        if (last_we_cyc != cyc - 1 || busy) done_err++;
      end
      if (valid != '0) begin
        if ($countones(valid) != 1) valid_err++;
        for (int i = 0; i < NU; i++) begin
          if (valid[i]) begin
            if (outst[i]) valid_err++;
            outst[i] = 1'b1;
            opix[i]  = int'(vcount) * W + int'(hcount);
            disp_count[i]++;
          end
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_count == 0 && k < 400) begin
      tick();
      k++;
    end
    repeat (5) tick();
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_writes"}, wr_count, 8);
    for (int a = 0; a < W*H; a++) check({tag, "_addr_once"}, addr_seen[a], 1);
    check({tag, "_data"}, data_err, 0);
    check({tag, "_done_pulses"}, done_count, 1);
    check({tag, "_done_timing"}, done_err, 0);
    check({tag, "_valid_rules"}, valid_err, 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  localparam logic [47:0] O1 = 48'h0011_0022_0033;
  localparam logic [47:0] O2 = 48'h0aaa_0bbb_0ccc;

  initial begin
    int k, wc;
    rst = 1'b0; start = 1'b0; origin = '0; fwd = '0; sel = '0;
    for (int i = 0; i < NU; i++) begin dur[i] = 3; nr[i] = 1'b0; end
    repeat (3) tick();

    check("rst_we", fb_we, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_addr", fb_addr, 0);

    // Frame 1: timing of the first dispatches and writes, stray start mid-frame.
    rst = 1'b1;
    tick();
    origin = O1; fwd = 48'h0000_0000_0100; sel = 3'd5;
    pulse_start();                                     // cycle 1
    check("f1_busy_c1", busy, 1);
    check("f1_valid_c1", valid, 0);
    check("f1_origin_latched", origin_out, O1);
    check("f1_sel_latched", sel_out, 5);
    tick();                                            // cycle 2
    check("f1_valid_c2", valid, 2'b01);
    check("f1_h_c2", hcount, 0);
    check("f1_v_c2", vcount, 0);
    origin = O2;
    start  = 1'b1;
    tick();                                            // cycle 3
    start = 1'b0;
    check("f1_valid_c3", valid, 2'b10);
    check("f1_h_c3", hcount, 1);
    tick();                                            // cycle 4
    check("f1_no_relatch", origin_out, O1);
    repeat (3) tick();                                 // cycle 7
    check("f1_we_c7", fb_we, 0);
    tick();                                            // cycle 8
    check("f1_we_c8", fb_we, 1);
    check("f1_addr_c8", fb_addr, 0);
    check("f1_data_c8", fb_data, 0);
    tick();                                            // cycle 9
    check("f1_we_c9", fb_we, 1);
    check("f1_addr_c9", fb_addr, 1);
    check("f1_data_c9", fb_data, 1);
    check("f1_valid_c9", valid, 2'b01);
    check("f1_h_c9", hcount, 2);
    wait_done();
    check_frame("f1");
    check("f1_origin_kept", origin_out, O2 ^ O2 ^ O1);

    // Reset mid-frame after three writes, then a clean frame.
    pulse_start();
    k = 0;
    while (wr_count < 3 && k < 200) begin tick(); k++; end
    check("mid_reached_3_writes", wr_count >= 3, 1);
    rst = 1'b0;
    tick();
    check("mid_rst_we", fb_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_addr", fb_addr, 0);
    check("mid_rst_data", fb_data, 0);
    check("mid_rst_h", hcount, 0);
    check("mid_rst_origin", origin_out, 0);
    wc = wr_count;
    rst = 1'b1;
    repeat (30) tick();
    check("mid_no_more_writes", wr_count, wc);
    check("mid_idle_busy", busy, 0);
    pulse_start();
    wait_done();
    check_frame("restart");

    // Simultaneous completion with pointer freshly reset to 0.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    dur[0] = 4;
    tick();
    pulse_start();                                     // cycle 1
    tick();                                            // cycle 2
    check("sim_valid_c2", valid, 2'b01);
    repeat (6) tick();                                 // cycle 8
    check("sim_we_c8", fb_we, 0);
    tick();                                            // cycle 9
    check("sim_we_c9", fb_we, 1);
    check("sim_addr_c9", fb_addr, 0);
    tick();                                            // cycle 10
    check("sim_we_c10", fb_we, 1);
    check("sim_addr_c10", fb_addr, 1);
    check("sim_valid_c10", valid, 2'b01);
    check("sim_h_c10", hcount, 2);
    tick();                                            // cycle 11
    check("sim_valid_c11", valid, 2'b10);
    check("sim_h_c11", hcount, 3);
    wait_done();
    check_frame("sim");

    // Unit 0 never ready: the whole frame goes to unit 1.
    dur[0] = 3;
    nr[0]  = 1'b1;
    pulse_start();
    wait_done();
    check_frame("u0off");
    check("u0off_disp_u0", disp_count[0], 0);
    check("u0off_disp_u1", disp_count[1], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
